// File: rtl/ternary_seq_ctrl_if.sv
// ternary_seq_ctrl_if: command/data word stream with valid/ready handshake
// cmd_in    : command or data word, driven by the master
// cmd_valid : cmd_in valid this cycle, driven by the master
// cmd_ready : word accepted when cmd_valid & cmd_ready, driven by the slave
interface ternary_seq_ctrl_if #(parameter int CMD_W = 16);
  logic [CMD_W-1:0] cmd_in;
  logic cmd_valid;
  logic cmd_ready;
  modport master(output cmd_in, cmd_valid, input cmd_ready);
  modport slave(input cmd_in, cmd_valid, output cmd_ready);
endinterface

// File: rtl/ternary_seq_ctrl.sv
// ternary_seq_ctrl: LOAD/MULT/OUT phase sequencer for the ternary matrix-vector datapath
// clk, rst            : clock, synchronous active-high reset
// cmd                 : command/data word stream (slave side)
// cfg_param           : latched config, [6:3] = in_len-1, [2:0] = out_len-1
// load_we/addr/done   : weight load strobe, beat index, last-beat pulse
// mult_start          : one pulse per accepted input vector
// res_valid/res_idx   : output row currently presented
// rd_ena/addr/done    : weight readback strobe, beat index, last-beat pulse
// state               : 0 IDLE, 1 LOAD, 2 MULT, 3 OUT
module ternary_seq_ctrl #(
  parameter int MAX_IN_LEN = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int CMD_W = 16,
  localparam int AW = $clog2(MAX_IN_LEN),
  localparam int OW = $clog2(MAX_OUT_LEN)
) (
  input  logic clk,
  input  logic rst,
  ternary_seq_ctrl_if.slave cmd,
  output logic [6:0] cfg_param,
  output logic load_we,
  output logic [AW-1:0] load_addr,
  output logic load_done,
  output logic mult_start,
  output logic res_valid,
  output logic [OW-1:0] res_idx,
  output logic rd_ena,
  output logic [AW-1:0] rd_addr,
  output logic rd_done,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE, LOAD, MULT, OUT} state_t;
  state_t st, st_n;
  logic acc, busy, last;
  logic [3:0] op, drain, out_len;
  logic [AW-1:0] cnt;
  logic [7:0] prod, beats;
  assign acc = cmd.cmd_valid & cmd.cmd_ready;
  assign op = cmd.cmd_in[CMD_W-1 -: 4];
  assign state = st;
  assign out_len = {1'b0, cfg_param[2:0]} + 4'd1;
  // ceil(2*in*out/16) == ceil(in*out/8); this form never overflows 8 bits
  assign prod = ({4'd0, cfg_param[6:3]} + 8'd1) * ({5'd0, cfg_param[2:0]} + 8'd1);
  assign beats = (prod + 8'd7) >> 3;
  assign last = {{(8-AW){1'b0}}, cnt} == beats - 8'd1;
  always_comb begin
    st_n = st;
    case (st)
      IDLE: st_n = !acc ? IDLE : op == 4'hA ? LOAD : op == 4'hF ? MULT : op == 4'hB ? OUT : IDLE;
      LOAD: st_n = acc && last ? MULT : LOAD;
      MULT: st_n = acc && cmd.cmd_in == '0 ? IDLE : MULT;
      OUT: st_n = rd_done ? IDLE : OUT;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cfg_param <= 7'h7F;
      cnt <= '0;
      drain <= '0;
      busy <= 1'b0;
      cmd.cmd_ready <= 1'b1;
      load_we <= 1'b0;
      load_addr <= '0;
      load_done <= 1'b0;
      mult_start <= 1'b0;
      res_valid <= 1'b0;
      res_idx <= '0;
      rd_ena <= 1'b0;
      rd_addr <= '0;
      rd_done <= 1'b0;
    end else begin
      st <= st_n;
      load_we <= 1'b0;
      load_done <= 1'b0;
      mult_start <= 1'b0;
      rd_done <= 1'b0;
      if (st == IDLE && acc && op == 4'hA) cfg_param <= cmd.cmd_in[11:5];
      if (st == IDLE && acc && op == 4'hB) cmd.cmd_ready <= 1'b0;
      if (st == LOAD && acc) begin
        load_we <= 1'b1;
        load_addr <= cnt;
        load_done <= last;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      // input held off from the start pulse until the last result row has been shown
      if (st == MULT && acc && cmd.cmd_in != '0) begin
        mult_start <= 1'b1;
        cmd.cmd_ready <= 1'b0;
        busy <= 1'b1;
        drain <= '0;
      end
      if (busy) begin
        if (drain == out_len) begin
          res_valid <= 1'b0;
          busy <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end else begin
          res_valid <= 1'b1;
          res_idx <= drain[OW-1:0];
          drain <= drain + 4'd1;
        end
      end
      if (st == OUT) begin
        if (rd_done) begin
          rd_ena <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end else begin
          rd_ena <= 1'b1;
          rd_addr <= cnt;
          rd_done <= last;
          cnt <= last ? '0 : cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// tb_ternary_seq_ctrl: scoreboard bench with a phase-level reference model
module tb_ternary_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] cfg_param;
  logic load_we, load_done, mult_start, res_valid, rd_ena, rd_done;
  logic [3:0] load_addr, rd_addr;
  logic [2:0] res_idx;
  logic [1:0] state;
  int cyc = 0;
  int checks = 0;
  int errs = 0;
  typedef struct {int kind; int val; int cyc;} ev_t;
  ev_t q[$];
  int m_mode = 0;
  logic [6:0] m_cfg = 7'h7F;
  int m_k = 0;
  int low_until = 0;
  ternary_seq_ctrl_if #(.CMD_W(16)) cmd_if();
  ternary_seq_ctrl dut (
    .clk(clk), .rst(rst), .cmd(cmd_if),
    .cfg_param(cfg_param), .load_we(load_we), .load_addr(load_addr), .load_done(load_done),
    .mult_start(mult_start), .res_valid(res_valid), .res_idx(res_idx),
    .rd_ena(rd_ena), .rd_addr(rd_addr), .rd_done(rd_done), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask
  task automatic pop_chk(input int k, input int v);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errs++;
      $display("FAIL unexpected event kind=%0d val=%0d cyc=%0d", k, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        errs++;
        $display("FAIL event got kind=%0d val=%0d cyc=%0d exp kind=%0d val=%0d cyc=%0d",
                 k, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask
  // kinds: 0 load beat, 1 mult_start, 2 result row, 3 readback beat; val bit 4 = done pulse
  task automatic model(input logic [15:0] w, input int a);
    int il, ol, b;
    il = int'(m_cfg[6:3]) + 1;
    ol = int'(m_cfg[2:0]) + 1;
    b = (2 * il * ol + 15) / 16;
    if (m_mode == 0) begin
      if (w[15:12] == 4'hA) begin
        m_cfg = w[11:5];
        m_mode = 1;
        m_k = 0;
      end else if (w[15:12] == 4'hF) m_mode = 2;
      else if (w[15:12] == 4'hB) begin
        for (int j = 0; j < b; j++) q.push_back('{3, j + (j == b - 1 ? 16 : 0), a + 1 + j});
        low_until = a + b;
      end
    end else if (m_mode == 1) begin
      q.push_back('{0, m_k + (m_k == b - 1 ? 16 : 0), a});
      m_k++;
      if (m_k == b) begin
        m_k = 0;
        m_mode = 2;
      end
    end else if (w == 16'h0000) m_mode = 0;
    else begin
      q.push_back('{1, 0, a});
      for (int i = 0; i < ol; i++) q.push_back('{2, i, a + 1 + i});
      low_until = a + ol;
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("cmd_ready", int'(cmd_if.cmd_ready), int'(cyc > low_until));
      if (load_we) pop_chk(0, int'(load_addr) + (load_done ? 16 : 0));
      if (mult_start) pop_chk(1, 0);
      if (res_valid) pop_chk(2, int'(res_idx));
      if (rd_ena) pop_chk(3, int'(rd_addr) + (rd_done ? 16 : 0));
    end
  end
  task automatic step(input logic v, input logic [15:0] w, output logic a);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_in = w;
    a = v && cmd_if.cmd_ready;
    if (a) model(w, cyc + 1);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), a);
  endtask
  task automatic send(input logic [15:0] w);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 40 && !a; i++) step(1'b1, w, a);
    cmd_if.cmd_valid = 1'b0;
    if (!a) chk("send_timeout", 0, 1);
  endtask
  initial begin
    logic a;
    int n;
    logic [15:0] w;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", int'(state), 0);
    chk("rst_cfg", int'(cfg_param), 'h7F);
    chk("rst_ready", int'(cmd_if.cmd_ready), 1);
    chk("rst_strobes", int'({load_we, load_done, mult_start, res_valid, rd_ena, rd_done}), 0);
    chk("rst_counters", int'({load_addr, rd_addr, res_idx}), 0);
    send(16'hAFE0);
    for (int i = 0; i < 16; i++) send(16'($urandom));
    chk("full_load_state", int'(state), 2);
    send(16'h1234);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h5555, a);
      if (a) n++;
    end
    cmd_if.cmd_valid = 1'b0;
    chk("drop_count", n, 1);
    idle(12);
    send(16'h0000);
    chk("mult_exit_state", int'(state), 0);
    send(16'h3000);
    chk("ignored_op_state", int'(state), 0);
    send(16'hA320);
    chk("cfg_4x2", int'(cfg_param), 'h19);
    send(16'($urandom));
    chk("small_load1_state", int'(state), 2);
    send(16'h0000);
    send(16'hA240);
    send(16'($urandom));
    chk("small_load2_mid_state", int'(state), 1);
    send(16'($urandom));
    chk("small_load2_state", int'(state), 2);
    for (int i = 0; i < 3; i++) send(16'($urandom) | 16'h0001);
    idle(6);
    send(16'h0000);
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 0) begin
        case ($urandom_range(0, 3))
          0: w = {4'hA, 7'($urandom), 5'($urandom)};
          1: w = {4'hF, 12'($urandom)};
          2: w = {4'hB, 12'($urandom)};
          default: w = {4'($urandom_range(0, 9)), 12'($urandom)};
        endcase
      end else if (m_mode == 2) w = $urandom_range(0, 5) == 0 ? 16'h0000 : (16'($urandom) | 16'h0100);
      else w = 16'($urandom);
      step($urandom_range(0, 3) != 0, w, a);
    end
    cmd_if.cmd_valid = 1'b0;
    idle(20);
    for (int i = 0; i < 16 && m_mode == 1; i++) send(16'($urandom));
    if (m_mode == 2) send(16'h0000);
    idle(2);
    chk("random_end_state", int'(state), 0);
    send(16'hAFE0);
    for (int i = 0; i < 16; i++) send(16'($urandom));
    send(16'h0000);
    send(16'hB000);
    chk("out_state", int'(state), 3);
    idle(20);
    chk("out_done_state", int'(state), 0);
    send(16'hA7E0);
    for (int i = 0; i < 5; i++) send(16'($urandom));
    chk("abort_pre_state", int'(state), 1);
    cmd_if.cmd_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    m_mode = 0;
    m_cfg = 7'h7F;
    m_k = 0;
    low_until = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", int'(state), 0);
    chk("abort_load_we", int'(load_we), 0);
    chk("abort_cfg", int'(cfg_param), 'h7F);
    send(16'hF000);
    send(16'h00FF);
    idle(12);
    send(16'h0000);
    idle(3);
    chk("leftover_events", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ternary_seq_ctrl.md
Name: ternary_seq_ctrl

Overview:
Phase sequencer for the ternary matrix-vector datapath. It decodes the 16-bit command/data word stream and runs the LOAD, MULT and OUT phases. It drives the load, multiply and readback engines with beat counters, result-index strobes and done pulses. It applies backpressure on the input stream while multiply results drain.

Parameters:
MAX_IN_LEN, 16, maximum input-vector length (power of 2, ≤16)
MAX_OUT_LEN, 8, maximum output-vector length (power of 2, ≤8)
CMD_W, 16, command/data word width

Ports:
clk  in  1  single clock, all logic posedge
rst  in  1  reset, synchronous, active-high
cmd_in  in  CMD_W  command or data word ({ui_in, uio_in})
cmd_valid  in  1  cmd_in valid this cycle
cmd_ready  out  1  word accepted when cmd_valid & cmd_ready
cfg_param  out  7  latched config: [6:3] = in_len-1, [2:0] = out_len-1
load_we  out  1  weight word write strobe
load_addr  out  4  weight beat index
load_done  out  1  one-cycle pulse after last weight beat
mult_start  out  1  one-cycle pulse per accepted input vector
res_valid  out  1  result index valid
res_idx  out  3  output row currently presented
rd_ena  out  1  weight readback active
rd_addr  out  4  readback beat index
rd_done  out  1  one-cycle pulse after last readback beat
state  out  2  0 IDLE, 1 LOAD, 2 MULT, 3 OUT

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high. rst sampled high at a posedge gives state = IDLE, cfg_param = 7'h7F, all counters = 0, all strobes = 0, cmd_ready = 1 on the next cycle.
- Registering: all outputs are registered. A word is consumed only on valid & ready.
- Derived lengths:
  - in_len = cfg_param[6:3]+1; out_len = cfg_param[2:0]+1.
  - beats = ceil(2*in_len*out_len/16), computed in 8-bit unsigned arithmetic, range 1..16.
- IDLE (opcode = cmd_in[15:12]):
  - 0xA: cfg_param <= cmd_in[11:5]; go to LOAD. The new cfg applies from the first LOAD beat.
  - 0xF: go to MULT with the existing cfg.
  - 0xB: go to OUT.
  - Any other opcode: consumed and ignored; stay in IDLE.
- LOAD:
  - Each accepted word: load_we = 1 and load_addr = beat counter on the following cycle; counter increments.
  - On the beats-th beat: load_done pulses on the same cycle as that load_we; counter clears; next state MULT.
  - cmd_ready stays 1 throughout. Opcodes are not decoded; every word is weight data.
- MULT:
  - Accepted word == 0x0000: return to IDLE; no mult_start.
  - Accepted nonzero word at cycle t:
    - mult_start = 1 at t+1.
    - cmd_ready = 0 from t+1 to t+1+out_len inclusive, then 1 again.
    - res_valid = 1 for cycles t+2 .. t+1+out_len, with res_idx = 0 .. out_len-1.
  - Back-to-back vectors are accepted as soon as cmd_ready returns to 1.
- OUT:
  - cmd_ready = 0; input is ignored.
  - rd_ena = 1 for beats cycles with rd_addr = 0 .. beats-1.
  - rd_done pulses with the last beat; return to IDLE next cycle.
- Boundaries:
  - cmd_valid with cmd_ready = 0 is dropped, not queued.
  - load_addr wraps only via the clear at beats. It never exceeds 15.
  - Reset mid-phase aborts immediately; in-flight res_valid and rd_ena are cleared next cycle.
  - Weight storage is outside this block and is unaffected by reset.
  - Illegal state encodings cannot occur; the default branch returns to IDLE.

Test Plan:
- Reset with rst held 2 cycles, then released: state = 0, cfg_param = 0x7F, cmd_ready = 1, all strobes 0.
- Full-size load: cmd 0xAFE0 then 16 data words → 16 load_we pulses, load_addr 0..15, load_done with the 16th, state = 2 next cycle.
- Small loads:
  - cmd 0xA320 (in 4, out 2) → beats = 1; load_done on the first data word.
  - cmd 0xA240 (in 3, out 3) → beats = 2; load_done on the second data word.
- Multiply with out_len 8: in MULT, vector 0x1234 accepted at t → mult_start at t+1; cmd_ready low t+1..t+9; res_idx 0..7 at t+2..t+9; then word 0x0000 → state = 0.
- Input dropped during drain: in MULT, cmd_valid held with 0x5555 while cmd_ready = 0 → exactly one extra vector is accepted after ready returns. Separately, opcode 0x3000 in IDLE → ignored, state stays 0.
- Readback and abort: cmd 0xB000 with cfg 0x7F → rd_addr 0..15, rd_done on the 16th beat, state returns to 0. Separately, assert rst on beat 5 of a LOAD → state = 0 and load_we = 0 on the next cycle.
